exec_monitor: RTL and testbench
===============================

Name: exec_monitor

Overview:
- Synthesizable execution monitor that sits beside the pipelined datapath.
- Counts cycles and up to NUM_EVENTS pipeline events (branch taken, stall, forwarding, ...).
- Detects program halt (PC unchanged for HALT_THRESHOLD non-stalled cycles) and watchdog timeout.
- Exposes all counters through a registered readout port, so simulation and FPGA builds share one end-of-program mechanism.

Parameters:
- CNT_WIDTH, 32, width of every counter.
- HALT_THRESHOLD, 10, consecutive equal-PC non-stalled cycles needed to declare halt (>=1).
- MAX_CYCLES, 5000, watchdog limit on cycle_count; 0 disables the watchdog.
- NUM_EVENTS, 4, number of event counters (1..7).
- SEL_WIDTH, 3, width of rd_sel.

Ports:
- clock, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- enable, input, 1, start/run gate.
- clear, input, 1, synchronous soft clear.
- pc_current, input, 32, fetch-stage PC.
- stall, input, 1, pipeline stall.
- event_in, input, NUM_EVENTS, per-cycle event strobes.
- rd_sel, input, SEL_WIDTH, readout select.
- rd_data, output, CNT_WIDTH, registered selected counter.
- cycle_count, output, CNT_WIDTH, live cycle counter.
- state, output, 2, FSM state: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
- halted, output, 1, high while in HALTED.
- timeout, output, 1, high while in TIMEOUT.
- done, output, 1, one-cycle pulse on entry to HALTED or TIMEOUT.
- halt_pc, output, 32, PC latched at halt.

Behaviour:
- Reset, priority 1: state=IDLE; every counter, stable count, prev_pc, rd_data, halt_pc, halted, timeout and done clear to 0.
- clear, priority 2: same as reset except rd_data and halt_pc, which hold.
- IDLE:
  - Counters hold.
  - enable=1: go to RUN on that edge and load prev_pc<=pc_current. Nothing is counted on that edge.
- RUN with enable=1, each edge:
  - cycle_count increments.
  - event_count[i] increments when event_in[i]=1.
  - prev_pc<=pc_current.
- Stable-PC count (RUN):
  - pc_current==prev_pc and stall=0: increment.
  - stall=1: hold (neither increment nor reset).
  - PC differs and stall=0: reset to 0.
- Halt: on the edge where the stable count would reach HALT_THRESHOLD:
  - state<=HALTED, halt_pc<=pc_current, done<=1.
  - cycle_count still increments on that edge.
- Timeout: if MAX_CYCLES!=0, on the edge where cycle_count becomes MAX_CYCLES: state<=TIMEOUT, done<=1.
- Simultaneous halt and timeout on the same edge: HALTED wins; timeout stays 0.
- RUN with enable=0 (pause):
  - Counters, stable count and prev_pc frozen; state stays RUN.
  - Resuming compares against the frozen prev_pc.
- HALTED/TIMEOUT:
  - Terminal; all counters frozen; event_in, stall and enable ignored.
  - Exit only via clear or reset.
- done: high exactly one cycle; 0 otherwise.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- rd_data, 1-cycle latency:
  - rd_sel=0 selects cycle_count; rd_sel=k (1..NUM_EVENTS) selects event_count[k-1]; any other value gives 0.
  - Captures counter values as they stood before the same edge's update.

Test Plan:
- Reset, enable=1, PC 0,4,…,0x40, then hold 0x40 with stall=0 -> HALTED after 10 equal compares; halt_pc=0x40; done high one cycle; cycle_count then frozen.
- PC held at 0x20 with stall=1 for 20 cycles, then stall=0 -> no halt during stall; HALTED exactly 10 edges after stall falls.
- MAX_CYCLES=50, PC changes every cycle -> TIMEOUT when cycle_count=50; timeout=1, halted=0, done pulses once.
- HALT_THRESHOLD and MAX_CYCLES tuned so both fire on one edge -> state=HALTED, timeout=0.
- Pulse event_in[0] 7 times in RUN, then rd_sel=1 -> rd_data=7 one cycle later; rd_sel=6 with NUM_EVENTS=4 -> rd_data=0.
- CNT_WIDTH=4, MAX_CYCLES=0, 30 running cycles -> cycle_count saturates at 15. clear mid-RUN -> IDLE with counters 0 next cycle. reset mid-RUN -> all outputs 0.

Source files
------------

// File: rtl/exec_monitor.sv
// Execution monitor: cycle/event counters, halt and watchdog detection,
// and a registered counter readout port.
module exec_monitor #(
    parameter int CNT_WIDTH      = 32,
    parameter int HALT_THRESHOLD = 10,
    parameter int MAX_CYCLES     = 5000,
    parameter int NUM_EVENTS     = 4,
    parameter int SEL_WIDTH      = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [31:0]           pc_current,
    input  logic                  stall,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic [SEL_WIDTH-1:0]  rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [1:0]            state,
    output logic                  halted,
    output logic                  timeout,
    output logic                  done,
    output logic [31:0]           halt_pc
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_HALTED  = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [63:0]          MAXC    = 64'(MAX_CYCLES);
    localparam logic [31:0]          THR     = 32'(HALT_THRESHOLD);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0] ev_q [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] ev_d [NUM_EVENTS];
    logic [31:0]          stable_q, stable_d;
    logic [31:0]          prev_q, prev_d;
    logic [CNT_WIDTH-1:0] rd_q, rd_d;
    logic [31:0]          hpc_q, hpc_d;
    logic                 done_q, done_d;
    logic                 same_pc, halt_hit, to_hit;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign same_pc  = (pc_current == prev_q);
    assign halt_hit = !stall && same_pc && ((stable_q + 32'd1) >= THR);
    // Timeout fires only on the edge the counter actually steps onto the limit.
    assign to_hit   = (MAX_CYCLES != 0) && (cyc_q != CNT_MAX)
                      && ((64'(cyc_q) + 64'd1) == MAXC);

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        ev_d     = ev_q;
        stable_d = stable_q;
        prev_d   = prev_q;
        hpc_d    = hpc_q;
        done_d   = 1'b0;
        rd_d     = '0;
        if (rd_sel == '0) rd_d = cyc_q;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            if (32'(rd_sel) == 32'(k + 1)) rd_d = ev_q[k];
        end
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_RUN;
                    prev_d  = pc_current;
                end
            end
            S_RUN: begin
                if (enable) begin
                    cyc_d  = sat_inc(cyc_q);
                    prev_d = pc_current;
                    for (int i = 0; i < NUM_EVENTS; i++) begin
                        if (event_in[i]) ev_d[i] = sat_inc(ev_q[i]);
                    end
                    if (!stall) stable_d = same_pc ? stable_q + 32'd1 : 32'd0;
                    if (halt_hit) begin
                        state_d = S_HALTED;
                        hpc_d   = pc_current;
                        done_d  = 1'b1;
                    end else if (to_hit) begin
                        state_d = S_TIMEOUT;
                        done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < NUM_EVENTS; i++) ev_q[i] <= '0;
            if (reset) begin
                rd_q  <= '0;
                hpc_q <= '0;
            end
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            done_q   <= done_d;
            ev_q     <= ev_d;
            rd_q     <= rd_d;
            hpc_q    <= hpc_d;
        end
    end

    assign rd_data     = rd_q;
    assign cycle_count = cyc_q;
    assign state       = state_q;
    assign halted      = (state_q == S_HALTED);
    assign timeout     = (state_q == S_TIMEOUT);
    assign done        = done_q;
    assign halt_pc     = hpc_q;

endmodule

// File: tb/tb_exec_monitor.sv
// Bench for exec_monitor: four parameterisations share one stimulus stream,
// with a readout scoreboard and a vector table for rd_sel decoding.
module tb_exec_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] pc = '0;
    logic        stall = 1'b0;
    logic [3:0]  event_in = '0;
    logic [2:0]  rd_sel = '0;

    logic [31:0] rd0, c0, hp0, rd1, c1, hp1, rd2, c2, hp2, hp3;
    logic [3:0]  rd3, c3;
    logic [1:0]  st0, st1, st2, st3;
    logic        h0, t0, d0, h1, t1, d1, h2, t2, d2, h3, t3, d3;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sbq[$];

    typedef struct {
        logic [2:0]  sel;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[8];

    always #5 clock = ~clock;

    exec_monitor u0 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .pc_current(pc), .stall(stall), .event_in(event_in), .rd_sel(rd_sel),
        .rd_data(rd0), .cycle_count(c0), .state(st0), .halted(h0),
        .timeout(t0), .done(d0), .halt_pc(hp0)
    );

    exec_monitor #(.MAX_CYCLES(50)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .pc_current(pc), .stall(stall), .event_in(event_in), .rd_sel(rd_sel),
        .rd_data(rd1), .cycle_count(c1), .state(st1), .halted(h1),
        .timeout(t1), .done(d1), .halt_pc(hp1)
    );

    exec_monitor #(.HALT_THRESHOLD(3), .MAX_CYCLES(5)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .pc_current(pc), .stall(stall), .event_in(event_in), .rd_sel(rd_sel),
        .rd_data(rd2), .cycle_count(c2), .state(st2), .halted(h2),
        .timeout(t2), .done(d2), .halt_pc(hp2)
    );

    exec_monitor #(.CNT_WIDTH(4), .MAX_CYCLES(0)) u3 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .pc_current(pc), .stall(stall), .event_in(event_in), .rd_sel(rd_sel),
        .rd_data(rd3), .cycle_count(c3), .state(st3), .halted(h3),
        .timeout(t3), .done(d3), .halt_pc(hp3)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name, input logic [63:0] act);
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %0h", name, act);
        end else begin
            check(name, act, sbq.pop_front());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; clear = 1'b0; stall = 1'b0;
        event_in = '0; rd_sel = '0; pc = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic start(input logic [31:0] p);
        enable = 1'b1;
        pc = p;
        tick();
    endtask

    initial begin
        tbl[0] = '{3'd0, 64'd10};
        tbl[1] = '{3'd1, 64'd7};
        tbl[2] = '{3'd2, 64'd3};
        tbl[3] = '{3'd3, 64'd0};
        tbl[4] = '{3'd4, 64'd0};
        tbl[5] = '{3'd5, 64'd0};
        tbl[6] = '{3'd6, 64'd0};
        tbl[7] = '{3'd7, 64'd0};

        // Halt after a PC ramp then a hold
        do_reset();
        check("rst_state", st0, 0);
        check("rst_cycle", c0, 0);
        check("rst_rd", rd0, 0);
        check("rst_hpc", hp0, 0);
        check("rst_done", d0, 0);
        check("rst_flags", {h0, t0}, 0);
        start(32'h0);
        check("start_state", st0, 1);
        check("start_nocount", c0, 0);
        for (int i = 1; i <= 16; i++) begin
            pc = 32'(4 * i);
            tick();
        end
        check("ramp_cycle", c0, 16);
        repeat (9) tick();
        check("hold9_state", st0, 1);
        check("hold9_done", d0, 0);
        tick();
        check("halt_state", st0, 2);
        check("halt_flag", h0, 1);
        check("halt_done", d0, 1);
        check("halt_pc", hp0, 64'h40);
        check("halt_cycle", c0, 26);
        tick();
        check("done_once", d0, 0);
        pc = 32'h44; stall = 1'b1; event_in = 4'hf;
        repeat (3) tick();
        check("frozen_cycle", c0, 26);
        check("frozen_state", st0, 2);
        check("frozen_hpc", hp0, 64'h40);

        // Stall holds the stable count
        do_reset();
        start(32'h20);
        stall = 1'b1;
        repeat (20) tick();
        check("stall_state", st0, 1);
        check("stall_cycle", c0, 20);
        stall = 1'b0;
        repeat (9) tick();
        check("post_stall9", st0, 1);
        tick();
        check("post_stall10", st0, 2);
        check("post_stall_hpc", hp0, 64'h20);
        check("post_stall_cyc", c0, 30);

        // Watchdog
        do_reset();
        start(32'h0);
        for (int i = 1; i <= 49; i++) begin
            pc = pc + 32'd4;
            tick();
        end
        check("wd49_state", st1, 1);
        check("wd49_cycle", c1, 49);
        pc = pc + 32'd4;
        tick();
        check("wd_state", st1, 3);
        check("wd_flags", {h1, t1}, 2'b01);
        check("wd_done", d1, 1);
        check("wd_cycle", c1, 50);
        pc = pc + 32'd4;
        tick();
        check("wd_done_once", d1, 0);
        check("wd_frozen", c1, 50);

        // Halt and timeout on the same edge, then reset mid-run
        do_reset();
        start(32'h100);
        pc = 32'h104; tick();
        pc = 32'h108; tick();
        tick(); tick();
        check("both4_state", st2, 1);
        check("both4_cycle", c2, 4);
        rd_sel = 3'd0;
        sbq.push_back(64'd4);
        tick();
        sb_pop("both_rd_pre", rd2);
        check("both_state", st2, 2);
        check("both_flags", {h2, t2}, 2'b10);
        check("both_done", d2, 1);
        check("both_cycle", c2, 5);
        check("both_hpc", hp2, 64'h108);
        check("u0_running", st0, 1);
        do_reset();
        check("mrst_state0", st0, 0);
        check("mrst_cycle0", c0, 0);
        check("mrst_state2", st2, 0);
        check("mrst_hpc2", hp2, 0);
        check("mrst_rd2", rd2, 0);
        check("mrst_done2", d2, 0);

        // Events and readout decode
        do_reset();
        start(32'h0);
        for (int i = 0; i < 10; i++) begin
            pc = pc + 32'd4;
            event_in = {2'b00, (i < 3), (i < 7)};
            tick();
        end
        event_in = '0;
        enable = 1'b0;
        tick();
        check("pause_state", st0, 1);
        check("pause_cycle", c0, 10);
        for (int k = 0; k < 8; k++) begin
            rd_sel = tbl[k].sel;
            sbq.push_back(tbl[k].exp);
            tick();
            sb_pop($sformatf("rd_sel%0d", k), rd0);
        end
        check("pause_still", c0, 10);
        enable = 1'b1;
        rd_sel = 3'd0;
        sbq.push_back(64'd10);
        tick();
        sb_pop("rd_pre_update", rd0);
        check("resume_cycle", c0, 11);

        // Saturation at CNT_WIDTH=4
        do_reset();
        start(32'h0);
        event_in = 4'h1;
        for (int i = 0; i < 30; i++) begin
            pc = pc + 32'd4;
            tick();
        end
        check("sat_cycle", c3, 15);
        check("sat_state", st3, 1);
        event_in = '0;
        enable = 1'b0;
        rd_sel = 3'd1;
        sbq.push_back(64'd15);
        tick();
        sb_pop("sat_event", rd3);

        // Soft clear mid-run
        do_reset();
        start(32'h0);
        for (int i = 0; i < 5; i++) begin
            pc = pc + 32'd4;
            tick();
        end
        check("clr_pre_wd", st2, 3);
        rd_sel = 3'd0;
        sbq.push_back(64'd5);
        pc = pc + 32'd4;
        tick();
        sb_pop("clr_rd", rd0);
        check("clr_pre_cyc", c0, 6);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_state", st0, 0);
        check("clr_cycle", c0, 0);
        check("clr_rd_hold", rd0, 5);
        check("clr_wd_exit", st2, 0);
        check("clr_wd_flag", t2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
